// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core run/boot controller.
//   state_e              : controller FSM state encoding (3 bits, IDLE..ERR)
//   EBREAK               : RV ebreak encoding; the core never retires it
//   state_holds_core_rst : core reset level associated with each state
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_RESET_CORE = 3'd2,
    ST_RUN        = 3'd3,
    ST_STEP       = 3'd4,
    ST_HALT       = 3'd5,
    ST_ERR        = 3'd6
  } state_e;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  // RUN, STEP and HALT release the core so that HALT keeps architectural
  // state; every other state keeps it in reset.
  function automatic logic state_holds_core_rst(input state_e s);
    logic r;
    case (s)
      ST_RUN, ST_STEP, ST_HALT: r = 1'b0;
      default:                  r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imem_load_seq.sv
// Program load sequencer for the instruction memory.
//   clk, rst          : clock, synchronous active-high reset
//   en                : controller is in LOAD (drives ld_ready at the top)
//   restart           : load_start accepted; counter returns to word 0
//   ld_valid/ld_data/ld_last : load beat stream
//   accept_last       : a beat carrying ld_last was written this cycle
//   overflow          : a beat arrived with the memory already full
//   imem_we/imem_waddr/imem_wdata : registered write port, 1-cycle latency
module imem_load_seq #(
  parameter int IMEM_WORDS = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              accept_last,
  output logic              overflow,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata
);

  // One extra bit so the counter can represent "memory full".
  localparam int CNT_W = ADDR_W + 1;

  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;

  logic accept;
  logic full;
  logic write;

  // A restart in the same cycle as a beat wins: that beat belongs to the
  // abandoned load and is dropped.
  assign accept      = en & ld_valid & ~restart;
  assign full        = (cnt_q == CNT_W'(IMEM_WORDS));
  assign write       = accept & ~full;
  assign overflow    = accept & full;
  assign accept_last = write & ld_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= write;
      if (restart) begin
        cnt_q <= '0;
      end else if (write) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (write) begin
        waddr_q <= cnt_q[ADDR_W-1:0];
        wdata_q <= ld_data;
      end
    end
  end

  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run/boot controller for the single-cycle RV64 core.
//   load_start, ld_valid/ld_data/ld_last/ld_ready : program load port
//   run_req, halt_req, step_req                    : host control pulses
//   instr                                          : instruction at the core PC
//   imem_we/imem_waddr/imem_wdata                  : imem write port
//   core_rst, core_en                              : core reset / commit enable
//   state, halted, load_err, cycle_cnt             : status
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int ADDR_W     = 8,
  parameter int RST_CYCLES = 2,
  parameter int CYC_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic [31:0]       instr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              core_en,
  output logic [2:0]        state,
  output logic              halted,
  output logic              load_err,
  output logic [CYC_W-1:0]  cycle_cnt
);

  localparam int RCNT_W = $clog2(RST_CYCLES + 1);

  state_e             state_q, state_d;
  logic               core_rst_q;
  logic               load_err_q;
  logic [CYC_W-1:0]   cycle_cnt_q;
  logic [RCNT_W-1:0]  rst_cnt_q;

  logic is_ebreak;
  logic load_go;
  logic ld_last_done;
  logic ld_overflow;

  assign is_ebreak = (instr == EBREAK);

  // load_start is honoured only where it is a listed transition.
  assign load_go = load_start & ((state_q == ST_IDLE) | (state_q == ST_LOAD) |
                                 (state_q == ST_HALT) | (state_q == ST_ERR));

  imem_load_seq #(
    .IMEM_WORDS (IMEM_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_load (
    .clk         (clk),
    .rst         (rst),
    .en          (state_q == ST_LOAD),
    .restart     (load_go),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .accept_last (ld_last_done),
    .overflow    (ld_overflow),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (load_go)      state_d = ST_LOAD;
        else if (run_req) state_d = ST_RESET_CORE;
      end
      ST_LOAD: begin
        if (load_go)           state_d = ST_LOAD;
        else if (ld_overflow)  state_d = ST_ERR;
        else if (ld_last_done) state_d = ST_IDLE;
      end
      ST_RESET_CORE: begin
        if (rst_cnt_q == RCNT_W'(RST_CYCLES - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        // The halt_req cycle itself still commits through core_en.
        if (is_ebreak || halt_req) state_d = ST_HALT;
      end
      ST_STEP: state_d = ST_HALT;
      ST_HALT: begin
        if (load_go)       state_d = ST_LOAD;
        else if (run_req)  state_d = ST_RUN;
        else if (step_req) state_d = ST_STEP;
      end
      ST_ERR: begin
        if (load_go) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      core_rst_q  <= 1'b1;
      load_err_q  <= 1'b0;
      cycle_cnt_q <= '0;
      rst_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      core_rst_q <= state_holds_core_rst(state_d);
      // ERR is entered only by overflow and left only by load_start,
      // so the sticky flag is exactly "next state is ERR".
      load_err_q <= (state_d == ST_ERR);
      // Counter idles at zero, so each RESET_CORE visit starts from 0.
      if (state_q == ST_RESET_CORE) rst_cnt_q <= rst_cnt_q + 1'b1;
      else                          rst_cnt_q <= '0;
      if (state_q == ST_IDLE && state_d == ST_RESET_CORE) begin
        cycle_cnt_q <= '0;
      end else if (core_en && !(&cycle_cnt_q)) begin
        cycle_cnt_q <= cycle_cnt_q + 1'b1;
      end
    end
  end

  // Combinational so an ebreak at the PC never commits.
  assign core_en   = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !is_ebreak;
  assign ld_ready  = (state_q == ST_LOAD);
  assign halted    = (state_q == ST_HALT);
  assign state     = state_q;
  assign core_rst  = core_rst_q;
  assign load_err  = load_err_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule
